// File: rtl/alu_pkg.sv
// alu_pkg: shared MIPS ALU function codes, datapath defaults and the logic-slice truth-table helper.
package alu_pkg;
    localparam int WIDTH   = 32;
    localparam int SHAMT_W = 5;

    localparam logic [5:0] ALUFUNC_ADD = 6'b000000;
    localparam logic [5:0] ALUFUNC_SUB = 6'b000001;
    localparam logic [5:0] ALUFUNC_AND = 6'b011000;
    localparam logic [5:0] ALUFUNC_OR  = 6'b011110;
    localparam logic [5:0] ALUFUNC_XOR = 6'b010110;
    localparam logic [5:0] ALUFUNC_NOR = 6'b010001;
    localparam logic [5:0] ALUFUNC_A   = 6'b011010;
    localparam logic [5:0] ALUFUNC_SLL = 6'b100000;
    localparam logic [5:0] ALUFUNC_SRL = 6'b100001;
    localparam logic [5:0] ALUFUNC_SRA = 6'b100011;
    localparam logic [5:0] ALUFUNC_EQ  = 6'b110011;
    localparam logic [5:0] ALUFUNC_NEQ = 6'b110001;
    localparam logic [5:0] ALUFUNC_LT  = 6'b110101;
    localparam logic [5:0] ALUFUNC_LEZ = 6'b111101;
    localparam logic [5:0] ALUFUNC_GEZ = 6'b111001;
    localparam logic [5:0] ALUFUNC_GTZ = 6'b111111;

    typedef enum logic [1:0] {
        SEL_ADD   = 2'b00,
        SEL_LOGIC = 2'b01,
        SEL_SHIFT = 2'b10,
        SEL_CMP   = 2'b11
    } slice_sel_e;

    // Each result bit looks up f with {b,a} as the index, b being the MSB.
    function automatic logic [WIDTH-1:0] logic_lut(
        input logic [3:0]       f,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) r[i] = f[{b[i], a[i]}];
        return r;
    endfunction
endpackage

// File: rtl/barrel_shifter.sv
// barrel_shifter: combinational log shifter, stages 1/2/4/8/16; dir=1 shifts right, arith selects sign fill.
module barrel_shifter #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic [WIDTH-1:0]   din,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               dir,
    input  logic               arith,
    output logic [WIDTH-1:0]   dout
);
    logic [SHAMT_W:0][WIDTH-1:0] st;
    logic                        fill;

    assign fill  = arith & din[WIDTH-1];
    assign st[0] = din;

    for (genvar s = 0; s < SHAMT_W; s++) begin : g_stage
        localparam int N = 1 << s;
        assign st[s+1] = !shamt[s] ? st[s] :
                         dir       ? {{N{fill}}, st[s][WIDTH-1:N]} :
                                     {st[s][WIDTH-1-N:0], {N{1'b0}}};
    end

    assign dout = st[SHAMT_W];
endmodule

// File: rtl/alu_logic_shift.sv
// alu_logic_shift: registered bitwise-logic and barrel-shift slice of the MIPS ALU, one-cycle latency.
module alu_logic_shift
    import alu_pkg::*;
#(
    parameter int WIDTH   = alu_pkg::WIDTH,
    parameter int SHAMT_W = alu_pkg::SHAMT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [5:0]         alu_func,
    output logic [WIDTH-1:0]   logic_out,
    output logic [WIDTH-1:0]   shift_out,
    output logic [WIDTH-1:0]   result,
    output logic               out_valid
);
    logic [WIDTH-1:0] logic_nx;
    logic [WIDTH-1:0] shift_nx;
    logic [WIDTH-1:0] result_nx;
    slice_sel_e       sel;

    assign sel = slice_sel_e'(alu_func[5:4]);

    // Mode 10 falls out as SLL: bit 0 alone picks direction.
    barrel_shifter #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) u_shift (
        .din   (b),
        .shamt (shamt),
        .dir   (alu_func[0]),
        .arith (alu_func[1]),
        .dout  (shift_nx)
    );

    always_comb begin
        logic_nx  = logic_lut(alu_func[3:0], a, b);
        result_nx = sel == SEL_LOGIC ? logic_nx :
                    sel == SEL_SHIFT ? shift_nx : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            logic_out <= '0;
            shift_out <= '0;
            result    <= '0;
            out_valid <= 1'b0;
        end else begin
            logic_out <= logic_nx;
            shift_out <= shift_nx;
            result    <= result_nx;
            out_valid <= in_valid;
        end
    end
endmodule

// File: tb/tb_alu_logic_shift.sv
// tb_alu_logic_shift: directed and random scoreboard bench for alu_logic_shift.
module tb_alu_logic_shift;
    import alu_pkg::*;

    typedef struct packed {
        logic [31:0] lo;
        logic [31:0] sh;
        logic [31:0] res;
        logic        v;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [4:0]  shamt = '0;
    logic [5:0]  alu_func = '0;
    logic [31:0] logic_out, shift_out, result;
    logic        out_valid;

    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    alu_logic_shift dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .shamt     (shamt),
        .alu_func  (alu_func),
        .logic_out (logic_out),
        .shift_out (shift_out),
        .result    (result),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(logic [31:0] ma, logic [31:0] mb, logic [4:0] ms,
                                   logic [5:0] mf, logic mv);
        exp_t e;
        for (int i = 0; i < 32; i++) e.lo[i] = mf[{mb[i], ma[i]}];
        if (!mf[0])     e.sh = mb << ms;
        else if (mf[1]) e.sh = 32'($signed(mb) >>> ms);
        else            e.sh = mb >> ms;
        e.res = (mf[5:4] == 2'b01) ? e.lo : (mf[5:4] == 2'b10) ? e.sh : 32'h0;
        e.v   = mv;
        return e;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one operation, let one edge pass, then check against the scoreboard head.
    task automatic step(logic [31:0] sa, logic [31:0] sb_in, logic [4:0] ss, logic [5:0] sf,
                        logic sv, logic use_want, logic [31:0] want, string tag);
        exp_t e;
        a = sa; b = sb_in; shamt = ss; alu_func = sf; in_valid = sv;
        sb.push_back(model(sa, sb_in, ss, sf, sv));
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, "_empty"}, 32'h1, 32'h0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_logic"}, logic_out, e.lo);
            chk({tag, "_shift"}, shift_out, e.sh);
            chk({tag, "_result"}, result, e.res);
            chk({tag, "_valid"}, {31'h0, out_valid}, {31'h0, e.v});
            if (use_want) chk({tag, "_const"}, result, want);
        end
    endtask

    initial begin
        #2;
        chk("rst_logic", logic_out, 32'h0);
        chk("rst_shift", shift_out, 32'h0);
        chk("rst_result", result, 32'h0);
        chk("rst_valid", {31'h0, out_valid}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        step(32'h0000000A, 32'hFFFFFFDD, 5'd0, ALUFUNC_AND, 1'b1, 1'b1, 32'h00000008, "and");
        step(32'h0000000A, 32'hFFFFFFDD, 5'd0, ALUFUNC_OR,  1'b1, 1'b1, 32'hFFFFFFDF, "or");
        step(32'h0000000A, 32'hFFFFFFDD, 5'd0, ALUFUNC_XOR, 1'b0, 1'b1, 32'hFFFFFFD7, "xor");
        step(32'h0000000A, 32'hFFFFFFDD, 5'd0, ALUFUNC_NOR, 1'b1, 1'b1, 32'h00000020, "nor");
        step(32'h0000000A, 32'hFFFFFFDD, 5'd0, ALUFUNC_A,   1'b1, 1'b1, 32'h0000000A, "passa");
        step(32'h12345678, 32'hFFFFFFDD, 5'd22, ALUFUNC_SLL, 1'b1, 1'b1, 32'hF7400000, "sll22");
        step(32'h12345678, 32'hFFFFFFDD, 5'd3,  ALUFUNC_SRL, 1'b1, 1'b1, 32'h1FFFFFFB, "srl3");
        step(32'h12345678, 32'hFFFFFFDD, 5'd3,  ALUFUNC_SRA, 1'b1, 1'b1, 32'hFFFFFFFB, "sra3");
        step(32'h0, 32'h80000001, 5'd0, ALUFUNC_SLL, 1'b1, 1'b1, 32'h80000001, "sll0");
        step(32'h0, 32'h80000001, 5'd0, ALUFUNC_SRL, 1'b1, 1'b1, 32'h80000001, "srl0");
        step(32'h0, 32'h80000001, 5'd0, ALUFUNC_SRA, 1'b1, 1'b1, 32'h80000001, "sra0");
        step(32'h0, 32'h80000001, 5'd0, 6'b100010,   1'b1, 1'b1, 32'h80000001, "m10_0");
        step(32'h0, 32'h80000001, 5'd31, ALUFUNC_SRA, 1'b1, 1'b1, 32'hFFFFFFFF, "sra31");
        step(32'h0, 32'h80000001, 5'd31, ALUFUNC_SRL, 1'b1, 1'b1, 32'h00000001, "srl31");
        step(32'h0, 32'h80000001, 5'd31, ALUFUNC_SLL, 1'b1, 1'b1, 32'h80000000, "sll31");
        step(32'h0, 32'h00000003, 5'd4, 6'b100010, 1'b1, 1'b1, 32'h00000030, "m10_4");
        step(32'hF0F0F0F0, 32'hFF00FF00, 5'd4, 6'b010000, 1'b1, 1'b1, 32'h00000000, "f0000");
        step(32'hF0F0F0F0, 32'hFF00FF00, 5'd4, 6'b011111, 1'b1, 1'b1, 32'hFFFFFFFF, "f1111");
        step(32'hF0F0F0F0, 32'hFF00FF00, 5'd4, 6'b011100, 1'b1, 1'b1, 32'hFF00FF00, "f1100");
        step(32'h0000000A, 32'hFFFFFFDD, 5'd3, ALUFUNC_ADD, 1'b1, 1'b1, 32'h00000000, "add_sel");
        step(32'h0000000A, 32'hFFFFFFDD, 5'd3, ALUFUNC_GTZ, 1'b1, 1'b1, 32'h00000000, "cmp_sel");
        // Reset mid-cycle while outputs hold nonzero values.
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_logic", logic_out, 32'h0);
        chk("mid_rst_shift", shift_out, 32'h0);
        chk("mid_rst_result", result, 32'h0);
        chk("mid_rst_valid", {31'h0, out_valid}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step(32'hDEADBEEF, 32'hCAFEF00D, 5'd7, ALUFUNC_SRA, 1'b1, 1'b1, 32'hFF95FDE0, "post_rst");
        for (int i = 0; i < 1000; i++)
            step($urandom, $urandom, 5'($urandom_range(0, 31)), 6'($urandom_range(0, 63)),
                 1'($urandom_range(0, 1)), 1'b0, 32'h0, "rand");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
